layer_sequencer: RTL and testbench
==================================

// Module: layer_sequencer
// PURPOSE
//  Control FSM for one CNN layer pass: load feature map -> relu -> maxpool2d.
//  Streams MAP_WIDTH*MAP_WIDTH words from the memory block into the layer buffer.
//  Starts relu and maxpool2d with start/done handshakes; either stage can be bypassed.
//  A watchdog aborts a stage that never reports done. Sits between top-level control and the datapath.
// PARAMETERS
//  MAP_WIDTH     5     feature-map side; N = MAP_WIDTH*MAP_WIDTH words per map
//  TIMEOUT       1000  max cycles a stage may run before abort (>=2)
//  ADDR_W        $clog2(MAP_WIDTH*MAP_WIDTH)  word index width (derived, not overridden)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       async active-high reset
//  start        in   1       request a layer pass; accepted only in IDLE
//  relu_bypass  in   1       skip relu; sampled when start is accepted
//  pool_bypass  in   1       skip maxpool2d; sampled when start is accepted
//  busy         out  1       high from the cycle after accept until return to IDLE
//  done         out  1       1-cycle pulse on successful completion
//  error        out  1       sticky timeout flag; cleared when the next start is accepted
//  mem_rd_en    out  1       memory read strobe; data valid 1 cycle later
//  mem_rd_addr  out  ADDR_W  memory word index
//  buf_wr_en    out  1       write the returned word into the layer buffer
//  buf_wr_idx   out  ADDR_W  buffer word index (= mem_rd_addr of the previous cycle)
//  relu_start   out  1       1-cycle pulse to start relu
//  relu_done    in   1       relu completion (level or pulse)
//  pool_start   out  1       1-cycle pulse to start maxpool2d
//  pool_done    in   1       maxpool2d completion (level or pulse)
//  state_o      out  3       current state encoding (debug)
// BEHAVIOUR
//  Reset: state IDLE; every output 0, including error; bypass regs 0; counters 0.
//  Asserting rst mid-pass aborts the pass immediately. No done, no error.
//  States: IDLE, LOAD, DRAIN, RELU, POOL, DONE, ERR.
//  IDLE: start=1 -> LOAD; latch both bypass bits; clear error. start is ignored in every other state.
//  LOAD: mem_rd_en=1, mem_rd_addr=rd_cnt, where rd_cnt runs 0..N-1 (one per cycle, no stalls).
//    After index N-1 -> DRAIN.
//  Buffer write: buf_wr_en/buf_wr_idx are registered copies of mem_rd_en/mem_rd_addr.
//    Writes therefore occur in the LOAD cycles after the first and in DRAIN.
//  DRAIN: the last buffer write; no read. Next state: RELU if !relu_bypass, else POOL if !pool_bypass, else DONE.
//  RELU: relu_start=1 only in the entry cycle. relu_done is ignored in the entry cycle.
//    relu_done=1 in a later cycle -> POOL, or DONE if pool_bypass.
//  POOL: same rules as RELU, using pool_start/pool_done -> DONE.
//  Watchdog: loaded with TIMEOUT-1 on entry to RELU/POOL; decrements each cycle the state is held.
//    If it is at 0 and done=0 -> ERR. If done=1 and the counter reaches 0 in the same cycle, done wins.
//  DONE: done=1 for exactly one cycle -> IDLE.
//  ERR: error<=1 (sticky) -> IDLE next cycle; done is not asserted.
//  busy=1 in every state except IDLE. It drops in the same cycle done pulses? No: busy=1 during the DONE cycle.
//  start held high continuously re-triggers a pass on each return to IDLE (one IDLE cycle between passes).
// STRUCTURE
//  Shared package cnn_ctrl_pkg: seq_state_e (3-bit enum, IDLE=0), DEFAULT_TIMEOUT constant.
//  Sub-module stage_watchdog (load, en, expired; width $clog2(TIMEOUT)), reusable by other controllers.
//  Everything else (FSM, rd_cnt, write-pipeline regs) stays in this module.
// TESTING (MAP_WIDTH=5, N=25, TIMEOUT=8; cycle 0 = edge on which start=1 is sampled)
//  Full pass, no bypass, relu_done at cycle 30, pool_done at cycle 34:
//    mem_rd_en cycles 1..25 with addr 0..24; buf_wr_en cycles 2..26 with idx 0..24.
//    relu_start at 27, pool_start at 31, done at 35, busy 1..35.
//  Both bypass bits set: no relu_start/pool_start; done=1 at cycle 27; IDLE at 28.
//  relu_done stuck 1 from cycle 0: relu_start at 27, transition to POOL at 28 (entry-cycle done ignored).
//  relu_done never asserted: ERR at cycle 35, error=1 from 36; the next start clears error and runs normally.
//  rst pulsed at cycle 10 of LOAD: all outputs 0 immediately; no done/error; the next start restarts at addr 0.
//  start pulsed during POOL: ignored; exactly one done pulse; rd_cnt is not disturbed.

Source files
------------

// File: rtl/cnn_ctrl_pkg.sv
// Shared types for CNN layer control.
// Sequencer state encoding and default watchdog limit.
package cnn_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    RELU  = 3'd3,
    POOL  = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } seq_state_e;

  localparam int DEFAULT_TIMEOUT = 1000;

endpackage

// File: rtl/layer_sequencer_if.sv
// Datapath-side bundle of the layer sequencer:
// memory read, buffer write and stage start/done.
interface layer_sequencer_if #(
  parameter int ADDR_W = 5
);

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              buf_wr_en;
  logic [ADDR_W-1:0] buf_wr_idx;
  logic              relu_start;
  logic              relu_done;
  logic              pool_start;
  logic              pool_done;

  modport master (
    output mem_rd_en, mem_rd_addr,
    output buf_wr_en, buf_wr_idx,
    output relu_start, pool_start,
    input  relu_done, pool_done
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr,
    input  buf_wr_en, buf_wr_idx,
    input  relu_start, pool_start,
    output relu_done, pool_done
  );

endinterface

// File: rtl/stage_watchdog.sv
// Down-counting stage watchdog: load arms it with TIMEOUT-1,
// en counts down, expired is high while the count sits at 0.
module stage_watchdog
  import cnn_ctrl_pkg::*;
#(
  parameter int  TIMEOUT = DEFAULT_TIMEOUT,
  localparam int W       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = W'(TIMEOUT - 1);
    else if (en && cnt_q != '0)
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/layer_sequencer.sv
// One CNN layer pass: stream the map into the buffer,
// then run relu and maxpool2d (each optional) under a watchdog.
module layer_sequencer
  import cnn_ctrl_pkg::*;
#(
  parameter int  MAP_WIDTH = 5,
  parameter int  TIMEOUT   = DEFAULT_TIMEOUT,
  localparam int N         = MAP_WIDTH * MAP_WIDTH,
  localparam int ADDR_W    = $clog2(N)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       relu_bypass,
  input  logic       pool_bypass,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [2:0] state_o,
  layer_sequencer_if.master dp
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_W-1:0] buf_wr_idx_q, buf_wr_idx_d;
  logic              buf_wr_en_q, buf_wr_en_d;
  logic              relu_byp_q, relu_byp_d;
  logic              pool_byp_q, pool_byp_d;
  logic              error_q, error_d;
  logic              entry_q, entry_d;
  logic              in_stage, wd_load, wd_en, wd_expired;

  stage_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .load    (wd_load),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    rd_cnt_d   = rd_cnt_q;
    relu_byp_d = relu_byp_q;
    pool_byp_d = pool_byp_q;
    error_d    = error_q;
    unique case (state_q)
      IDLE: if (start) begin
        state_d    = LOAD;
        rd_cnt_d   = '0;
        relu_byp_d = relu_bypass;
        pool_byp_d = pool_bypass;
        error_d    = 1'b0;
      end
      LOAD: begin
        if (rd_cnt_q == ADDR_W'(N - 1)) begin
          state_d  = DRAIN;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (!relu_byp_q)      state_d = RELU;
        else if (!pool_byp_q) state_d = POOL;
        else                  state_d = DONE;
      end
      // done is not trusted in the entry cycle; done beats expiry
      RELU: begin
        if (!entry_q && dp.relu_done)
          state_d = pool_byp_q ? DONE : POOL;
        else if (wd_expired)
          state_d = ERR;
      end
      POOL: begin
        if (!entry_q && dp.pool_done)
          state_d = DONE;
        else if (wd_expired)
          state_d = ERR;
      end
      DONE: state_d = IDLE;
      ERR: begin
        error_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    entry_d      = (state_d != state_q);
    in_stage     = (state_d == RELU) || (state_d == POOL);
    wd_load      = in_stage && entry_d;
    wd_en        = in_stage && !entry_d;
    buf_wr_en_d  = (state_q == LOAD);
    buf_wr_idx_d = rd_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      buf_wr_idx_q <= '0;
      buf_wr_en_q  <= 1'b0;
      relu_byp_q   <= 1'b0;
      pool_byp_q   <= 1'b0;
      error_q      <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      buf_wr_idx_q <= buf_wr_idx_d;
      buf_wr_en_q  <= buf_wr_en_d;
      relu_byp_q   <= relu_byp_d;
      pool_byp_q   <= pool_byp_d;
      error_q      <= error_d;
      entry_q      <= entry_d;
    end
  end

  assign dp.mem_rd_en   = (state_q == LOAD);
  assign dp.mem_rd_addr = rd_cnt_q;
  assign dp.buf_wr_en   = buf_wr_en_q;
  assign dp.buf_wr_idx  = buf_wr_idx_q;
  assign dp.relu_start  = (state_q == RELU) && entry_q;
  assign dp.pool_start  = (state_q == POOL) && entry_q;
  assign busy           = (state_q != IDLE);
  assign done           = (state_q == DONE);
  assign error          = error_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: expected output events
// are queued per pass and matched against observed strobes/edges.
module tb_layer_sequencer;

  localparam int MW = 5;
  localparam int N  = MW * MW;
  localparam int TO = 8;
  localparam int AW = 5;

  localparam int K_RD = 1;
  localparam int K_WR = 2;
  localparam int K_RS = 3;
  localparam int K_PS = 4;
  localparam int K_DN = 5;
  localparam int K_BZ = 6;
  localparam int K_ER = 7;

  typedef struct {
    int k;
    int c;
    int v;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       relu_bypass = 1'b0;
  logic       pool_bypass = 1'b0;
  logic       busy, done, error;
  logic [2:0] state_o;

  layer_sequencer_if #(.ADDR_W(AW)) dp ();

  layer_sequencer #(
    .MAP_WIDTH (MW),
    .TIMEOUT   (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .relu_bypass (relu_bypass),
    .pool_bypass (pool_bypass),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .state_o     (state_o),
    .dp          (dp.master)
  );

  always #5 clk = ~clk;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  busy_p = 1'b0;
  bit  err_p = 1'b0;
  bit  err_model = 1'b0;
  int  nx, nx2;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int code(int k, int c, int v);
    return k * 1000000 + c * 1000 + v;
  endfunction

  function automatic string kname(int k);
    case (k)
      K_RD:    return "mem_rd";
      K_WR:    return "buf_wr";
      K_RS:    return "relu_start";
      K_PS:    return "pool_start";
      K_DN:    return "done";
      K_BZ:    return "busy_edge";
      K_ER:    return "error_edge";
      default: return "event";
    endcase
  endfunction

  function automatic void push(int k, int c, int v);
    ev_t e;
    e.k = k;
    e.c = c;
    e.v = v;
    sb.push_back(e);
  endfunction

  // first cycle after entry t where a done input is high, within the watchdog window
  function automatic int stage_exit(int t, int from, int to);
    for (int c = t + 1; c <= t + TO - 1; c++)
      if (c >= from && c <= to) return c;
    return -1;
  endfunction

  task automatic gen_pass(input int off, input bit rb, input bit pb,
                          input int rf, input int rt,
                          input int pf, input int pt,
                          output int nxt);
    int t, c, rs, ps, dn, er, fin;
    t  = off + N + 2;
    rs = -1;
    ps = -1;
    dn = -1;
    er = -1;
    if (!rb) begin
      rs = t;
      c  = stage_exit(t, rf, rt);
      if (c < 0) er = t + TO;
      else       t  = c + 1;
    end
    if (er < 0 && !pb) begin
      ps = t;
      c  = stage_exit(t, pf, pt);
      if (c < 0) er = t + TO;
      else       t  = c + 1;
    end
    if (er < 0) dn = t;
    fin = (er >= 0) ? er : dn;
    for (int i = off + 1; i <= fin + 1; i++) begin
      int r;
      r = i - off;
      if (r >= 1 && r <= N)     push(K_RD, i, r - 1);
      if (r >= 2 && r <= N + 1) push(K_WR, i, r - 2);
      if (i == rs)              push(K_RS, i, 0);
      if (i == ps)              push(K_PS, i, 0);
      if (i == dn)              push(K_DN, i, 0);
      if (r == 1)               push(K_BZ, i, 1);
      if (i == fin + 1)         push(K_BZ, i, 0);
      if (r == 1 && err_model)  push(K_ER, i, 0);
      if (er >= 0 && i == er + 1) push(K_ER, i, 1);
    end
    err_model = (er >= 0);
    nxt = fin + 1;
  endtask

  task automatic obs(input int k, input int v);
    ev_t e;
    if (sb.size() == 0) begin
      check("unexpected_event", code(k, cyc, v), 0);
    end else begin
      e = sb.pop_front();
      check(kname(e.k), code(k, cyc, v), code(e.k, e.c, e.v));
    end
  endtask

  task automatic mon();
    if (dp.mem_rd_en)  obs(K_RD, int'(dp.mem_rd_addr));
    if (dp.buf_wr_en)  obs(K_WR, int'(dp.buf_wr_idx));
    if (dp.relu_start) obs(K_RS, 0);
    if (dp.pool_start) obs(K_PS, 0);
    if (done)          obs(K_DN, 0);
    if (busy !== busy_p)  obs(K_BZ, int'(busy));
    if (error !== err_p)  obs(K_ER, int'(error));
    busy_p = busy;
    err_p  = error;
  endtask

  // bypass bits are flipped whenever start is low to prove they are latched
  task automatic apply(input bit rb, input bit pb, input int rf, input int rt,
                       input int pf, input int pt, input int s2,
                       input int st_to);
    start        = (cyc <= st_to) || (cyc == s2);
    relu_bypass  = start ? rb : !rb;
    pool_bypass  = start ? pb : !pb;
    dp.relu_done = (cyc >= rf && cyc <= rt);
    dp.pool_done = (cyc >= pf && cyc <= pt);
  endtask

  task automatic drive(input int ncyc, input bit rb, input bit pb,
                       input int rf, input int rt, input int pf,
                       input int pt, input int s2, input int st_to,
                       input int rst_at);
    cyc = 0;
    apply(rb, pb, rf, rt, pf, pt, s2, st_to);
    for (int n = 0; n < ncyc; n++) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mon();
      if (cyc == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_state", state_o, 0);
        check("rst_mem_rd_en", dp.mem_rd_en, 0);
        check("rst_mem_rd_addr", dp.mem_rd_addr, 0);
        check("rst_buf_wr_en", dp.buf_wr_en, 0);
        busy_p    = 1'b0;
        err_p     = 1'b0;
        err_model = 1'b0;
        break;
      end
      apply(rb, pb, rf, rt, pf, pt, s2, st_to);
    end
    start        = 1'b0;
    relu_bypass  = 1'b0;
    pool_bypass  = 1'b0;
    dp.relu_done = 1'b0;
    dp.pool_done = 1'b0;
    if (rst) begin
      @(negedge clk);
      rst = 1'b0;
    end
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mon();
    end
    check("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    dp.relu_done = 1'b0;
    dp.pool_done = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_state", state_o, 0);
    check("reset_mem_rd_en", dp.mem_rd_en, 0);
    check("reset_buf_wr_en", dp.buf_wr_en, 0);
    check("reset_relu_start", dp.relu_start, 0);
    check("reset_pool_start", dp.pool_start, 0);
    rst = 1'b0;
    @(negedge clk);

    // full pass, relu_done at 30, pool_done at 34
    gen_pass(0, 0, 0, 30, 30, 34, 34, nx);
    drive(40, 0, 0, 30, 30, 34, 34, -1, 0, -1);

    // both stages bypassed
    gen_pass(0, 1, 1, -1, -2, -1, -2, nx);
    drive(32, 1, 1, -1, -2, -1, -2, -1, 0, -1);

    // relu_done stuck high, pool bypassed
    gen_pass(0, 0, 1, 0, 999, -1, -2, nx);
    drive(34, 0, 1, 0, 999, -1, -2, -1, 0, -1);

    // relu never completes
    gen_pass(0, 0, 0, -1, -2, -1, -2, nx);
    drive(40, 0, 0, -1, -2, -1, -2, -1, 0, -1);

    // recovery; pool_done on the watchdog's last cycle
    gen_pass(0, 0, 0, 28, 28, 36, 36, nx);
    drive(42, 0, 0, 28, 28, 36, 36, -1, 0, -1);

    // pool never completes, relu bypassed
    gen_pass(0, 1, 0, -1, -2, -1, -2, nx);
    drive(40, 1, 0, -1, -2, -1, -2, -1, 0, -1);

    // stray start during POOL
    gen_pass(0, 0, 0, 30, 30, 34, 34, nx);
    drive(40, 0, 0, 30, 30, 34, 34, 32, 0, -1);

    // reset in the middle of LOAD
    for (int i = 1; i <= 10; i++) begin
      push(K_RD, i, i - 1);
      if (i >= 2) push(K_WR, i, i - 2);
      if (i == 1) push(K_BZ, i, 1);
    end
    drive(40, 0, 0, -1, -2, -1, -2, -1, 0, 10);
    gen_pass(0, 1, 1, -1, -2, -1, -2, nx);
    drive(32, 1, 1, -1, -2, -1, -2, -1, 0, -1);

    // start held high: back-to-back passes
    gen_pass(0, 1, 1, -1, -2, -1, -2, nx);
    gen_pass(nx, 1, 1, -1, -2, -1, -2, nx2);
    drive(nx2 + 4, 1, 1, -1, -2, -1, -2, -1, nx2 - 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
